colmem_tap_arbiter: RTL and testbench
=====================================

# colmem_tap_arbiter

Parametrised capture stage that sits on the per-column core readout of one section. It timestamps every column-memory read, buffers it in a per-column FIFO and round-robin merges all columns into one tagged, ready/valid stream. The stream feeds the EOS monitor and debug readout, so that each column no longer needs its own probe. It adds column masking, overflow accounting and back-pressure.

## Interface
- COLUMNS, `ARCADIA_SECTION_COLUMNS`, number of tapped columns (≥2)
- DATA_BITS, `ARCADIA_CORE_DATA_BITS`, width of one column-memory word
- DEPTH, 4, entries per column FIFO (power of 2, ≥2)
- TS_BITS, 16, timestamp counter width
- CW, $clog2(COLUMNS), column-index width
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  global capture enable
- col_mask  in  COLUMNS  1 = column captured
- colmem_read  in  COLUMNS  per-column read strobe
- colmem_out  in  COLUMNS×DATA_BITS  per-column read data, valid with strobe
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts when high with out_valid
- out_col  out  CW  source column of output word
- out_data  out  DATA_BITS  captured word
- out_ts  out  TS_BITS  timestamp at capture
- clear_stats  in  1  clears drop_count and overflow
- drop_count  out  16  total dropped captures, saturating
- overflow  out  COLUMNS  sticky per-column drop flag

## Operation
- ts: free-running counter, +1 every cycle, wraps 2^TS_BITS−1 → 0; runs regardless of enable.
- Capture: in a cycle where enable & col_mask[c] & colmem_read[c] is high, push {colmem_out[c], ts} into FIFO c. All columns may push in the same cycle.
- Full FIFO: a push is accepted if count < DEPTH, or if FIFO c is popped in the same cycle (count stays DEPTH). Otherwise the word is dropped, overflow[c] is set and drop_count increments, saturating at 16'hFFFF. Several drops in one cycle add their number (saturating).
- Output register: loads when out_valid = 0 or (out_valid & out_ready). It loads from the round-robin winner among non-empty FIFOs and pops that FIFO. If no FIFO is non-empty, out_valid goes to 0.
- Arbitration: search starts at rr_ptr and wraps modulo COLUMNS. On a grant, rr_ptr ← winner+1 (mod COLUMNS). rr_ptr is unchanged when there is no grant.
- Output stability: while out_valid & !out_ready, out_col, out_data and out_ts hold.
- enable/col_mask low: stops new captures only. Already-buffered words still drain.
- clear_stats: drop_count ← number of drops in the same cycle; overflow ← the same-cycle drop set. A drop coincident with the clear therefore survives it.
- Reset values:
  - All FIFOs empty, rr_ptr = 0, ts = 0.
  - out_valid = 0, out_col = 0, out_data = 0, out_ts = 0.
  - drop_count = 0, overflow = 0.
- Reset mid-operation discards all buffered data.

## Timing
- Capture → output: a read strobed in cycle N is written at edge N. It is visible on out_valid after edge N+1 if its FIFO wins and the register is free. Minimum latency is 2 cycles.
- out_ts equals the ts value sampled in cycle N.
- Throughput is one word per cycle while out_ready is held high.
- drop_count and overflow update at the edge ending the drop cycle.
- Reset is honoured at the next rising edge and overrides all other inputs that cycle.

## Test plan
- Single capture (COLUMNS=4, DATA_BITS=8, DEPTH=4):
  - Stimulus: reset, then strobe col 2 with 0xA5 at ts=10, out_ready=1.
  - Required: out_valid for one cycle two cycles later, with out_col=2, out_data=0xA5, out_ts=10.
- Round-robin:
  - Stimulus: cols 0–3 strobe 0x10–0x13 in the same cycle.
  - Required: output order col 0,1,2,3 in four consecutive cycles.
  - Stimulus: then col 1 and col 3 strobe together.
  - Required: col 1 first, since rr_ptr wrapped to 0.
- Back-pressure/overflow:
  - Stimulus: out_ready=0, col 0 strobed 6 consecutive cycles with 0x01..0x06.
  - Required: out holds 0x01; FIFO holds 0x02..0x05; 0x06 dropped; drop_count=1; overflow=4'b0001.
  - Stimulus: release out_ready.
  - Required: 0x01..0x05 delivered in order.
- Mask/enable:
  - Stimulus: col_mask=4'b1011, strobe all columns.
  - Required: col 2 absent from output.
  - Stimulus: enable=0 with strobes.
  - Required: no output and drop_count unchanged.
- Stats clear and saturation:
  - Stimulus: force 0xFFFF+3 drops.
  - Required: drop_count=0xFFFF.
  - Stimulus: clear_stats in the same cycle as one col-3 drop.
  - Required: drop_count=1, overflow=4'b1000.
- Reset mid-stream and ts wrap:
  - Stimulus: reset with 3 words buffered and out_valid=1.
  - Required: next cycle out_valid=0 and no further output.
  - Stimulus: capture at ts=0xFFFF and at the next cycle.
  - Required: out_ts 0xFFFF then 0x0000.

Source files
------------

// File: rtl/colmem_tap_arbiter.sv
// Per-column capture FIFOs with timestamping, merged round-robin into one tagged
// ready/valid stream, with column masking, saturating drop counting and sticky overflow flags.
`ifndef ARCADIA_SECTION_COLUMNS
`define ARCADIA_SECTION_COLUMNS 4
`endif
`ifndef ARCADIA_CORE_DATA_BITS
`define ARCADIA_CORE_DATA_BITS 8
`endif

module colmem_tap_arbiter #(
  parameter int unsigned COLUMNS   = `ARCADIA_SECTION_COLUMNS,
  parameter int unsigned DATA_BITS = `ARCADIA_CORE_DATA_BITS,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TS_BITS   = 16,
  parameter int unsigned CW        = $clog2(COLUMNS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [COLUMNS-1:0]             col_mask,
  input  logic [COLUMNS-1:0]             colmem_read,
  input  logic [COLUMNS*DATA_BITS-1:0]   colmem_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CW-1:0]                  out_col,
  output logic [DATA_BITS-1:0]           out_data,
  output logic [TS_BITS-1:0]             out_ts,
  input  logic                           clear_stats,
  output logic [15:0]                    drop_count,
  output logic [COLUMNS-1:0]             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = DATA_BITS + TS_BITS;

  logic [TS_BITS-1:0] ts;
  logic [EW-1:0]      mem [COLUMNS][DEPTH];
  logic [AW:0]        wr_ptr [COLUMNS];
  logic [AW:0]        rd_ptr [COLUMNS];
  logic [CW-1:0]      rr_ptr;

  logic [COLUMNS-1:0] nonempty, full, req, accept, pop, drop;
  logic               load, found;
  logic [CW-1:0]      winner;
  logic [CW:0]        idx, ndrop;
  logic [16:0]        drop_sum;

  always_comb begin
    nonempty = '0;
    full     = '0;
    req      = '0;
    for (int unsigned c = 0; c < COLUMNS; c++) begin
      nonempty[c] = (wr_ptr[c] != rd_ptr[c]);
      full[c]     = ((wr_ptr[c] - rd_ptr[c]) == (AW+1)'(DEPTH));
      req[c]      = enable & col_mask[c] & colmem_read[c];
    end
  end

  // Search order rr_ptr, rr_ptr+1, ... wrapping at COLUMNS (which need not be a power of 2).
  always_comb begin
    load   = !out_valid || out_ready;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < COLUMNS; i++) begin
      idx = {1'b0, rr_ptr} + (CW+1)'(i);
      if (idx >= (CW+1)'(COLUMNS)) idx = idx - (CW+1)'(COLUMNS);
      if (!found && nonempty[idx[CW-1:0]]) begin
        found  = 1'b1;
        winner = idx[CW-1:0];
      end
    end
    pop = '0;
    if (load && found) pop[winner] = 1'b1;
  end

  // A full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    accept = req & (~full | pop);
    drop   = req & ~accept;
    ndrop  = '0;
    for (int unsigned c = 0; c < COLUMNS; c++) ndrop = ndrop + (CW+1)'(drop[c]);
    drop_sum = {1'b0, drop_count} + 17'(ndrop);
  end

  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < COLUMNS; c++) begin
      if (accept[c])
        mem[c][wr_ptr[c][AW-1:0]] <= {colmem_out[c*DATA_BITS +: DATA_BITS], ts};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts         <= '0;
      rr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_col    <= '0;
      out_data   <= '0;
      out_ts     <= '0;
      drop_count <= '0;
      overflow   <= '0;
      for (int unsigned c = 0; c < COLUMNS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      ts <= ts + TS_BITS'(1);
      for (int unsigned c = 0; c < COLUMNS; c++) begin
        if (accept[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
        if (pop[c])    rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
      end
      if (load) begin
        if (found) begin
          out_valid            <= 1'b1;
          out_col              <= winner;
          {out_data, out_ts}   <= mem[winner][rd_ptr[winner][AW-1:0]];
          rr_ptr               <= (winner == CW'(COLUMNS-1)) ? '0 : winner + CW'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end
      // A drop in the clearing cycle is kept rather than lost.
      if (clear_stats) begin
        drop_count <= 16'(ndrop);
        overflow   <= drop;
      end else begin
        drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
        overflow   <= overflow | drop;
      end
    end
  end

endmodule

// File: tb/tb_colmem_tap_arbiter.sv
// Scoreboard bench for colmem_tap_arbiter: a queue-based reference model predicts the
// merged stream and statistics; a negedge monitor checks every accepted output word.
module tb_colmem_tap_arbiter;

  localparam int COLS = 4;
  localparam int DB   = 8;
  localparam int DEP  = 4;

  logic            clock = 1'b0;
  logic            reset, enable, out_ready, clear_stats;
  logic [COLS-1:0] col_mask, colmem_read;
  logic [COLS*DB-1:0] colmem_out;
  logic            out_valid;
  logic [1:0]      out_col;
  logic [DB-1:0]   out_data;
  logic [15:0]     out_ts;
  logic [15:0]     drop_count;
  logic [COLS-1:0] overflow;

  colmem_tap_arbiter #(.COLUMNS(COLS), .DATA_BITS(DB), .DEPTH(DEP), .TS_BITS(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .col_mask(col_mask),
    .colmem_read(colmem_read), .colmem_out(colmem_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_col(out_col), .out_data(out_data), .out_ts(out_ts),
    .clear_stats(clear_stats), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: per-column word queues plus the merged-stream scoreboard.
  logic [23:0]     q [COLS][$];
  logic [25:0]     sb [$];
  logic            m_valid;
  int              m_rr;
  logic [15:0]     m_ts;
  int              m_drop;
  logic [COLS-1:0] m_ovf;
  logic            m_after_reset;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Called 1 time unit after a rising edge: checks state, drives the next cycle, advances model.
  task automatic step(input logic r, input logic en, input logic [3:0] mask, input logic [3:0] rd,
                      input logic [31:0] data, input logic rdy, input logic clr);
    int ndrop;
    logic [3:0] dset;
    logic [23:0] e;
    int c;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_after_reset)
      check("reset_out_regs", {6'd0, out_col, out_data, out_ts}, 32'd0);

    reset = r; enable = en; col_mask = mask; colmem_read = rd; colmem_out = data;
    out_ready = r ? 1'b0 : rdy; clear_stats = clr;

    if (r) begin
      for (int k = 0; k < COLS; k++) q[k].delete();
      sb.delete();
      m_valid = 1'b0; m_rr = 0; m_ts = '0; m_drop = 0; m_ovf = '0; m_after_reset = 1'b1;
    end else begin
      m_after_reset = 1'b0;
      if (!m_valid || rdy) begin
        m_valid = 1'b0;
        for (int i = 0; i < COLS; i++) begin
          c = (m_rr + i) % COLS;
          if (!m_valid && q[c].size() > 0) begin
            e = q[c].pop_front();
            sb.push_back({2'(c), e});
            m_valid = 1'b1;
            m_rr = (c + 1) % COLS;
          end
        end
      end
      ndrop = 0; dset = '0;
      for (int k = 0; k < COLS; k++) begin
        if (en && mask[k] && rd[k]) begin
          if (q[k].size() < DEP) q[k].push_back({data[k*DB +: DB], m_ts});
          else begin ndrop++; dset[k] = 1'b1; end
        end
      end
      if (clr) begin
        m_drop = ndrop; m_ovf = dset;
      end else begin
        m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
        m_ovf  = m_ovf | dset;
      end
      m_ts = m_ts + 16'd1;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'hF, 4'h0, 32'h0, rdy, 1'b0);
  endtask

  // Monitor: every word the sink accepts must be the next one the model predicted.
  initial begin
    logic [25:0] exp;
    forever begin
      @(negedge clock);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got col=%0d data=0x%0h ts=0x%0h, want none", out_col, out_data, out_ts);
        end else begin
          exp = sb.pop_front();
          if ({out_col, out_data, out_ts} !== exp) begin
            miscompares++;
            $display("FAIL stream_word: got col=%0d data=0x%0h ts=0x%0h, want col=%0d data=0x%0h ts=0x%0h",
                     out_col, out_data, out_ts, exp[25:24], exp[23:16], exp[15:0]);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; col_mask = '0; colmem_read = '0; colmem_out = '0;
    out_ready = 1'b0; clear_stats = 1'b0;
    @(posedge clock); #1;
    m_valid = 1'b0; m_rr = 0; m_ts = '0; m_drop = 0; m_ovf = '0; m_after_reset = 1'b1;
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Single capture at ts=10 on column 2.
    while (m_ts != 16'd10) idle(1, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b0100, 32'h00A5_0000, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Round-robin across all columns, then cols 1 and 3 after the pointer wraps.
    step(1'b0, 1'b1, 4'hF, 4'hF, 32'h1312_1110, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b1010, 32'h2300_2100, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Back-pressure and overflow on column 0.
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 4'hF, 4'b0001, 32'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(8, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'h0, 32'h0, 1'b1, 1'b1);

    // Masking and global enable.
    step(1'b0, 1'b1, 4'b1011, 4'hF, 32'h4342_4140, 1'b1, 1'b0);
    idle(6, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'hF, 4'hF, 32'h5152_5354, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Drop counter saturation, then a clear coincident with a column-3 drop.
    for (int i = 0; i < 16400; i++) step(1'b0, 1'b1, 4'hF, 4'hF, $urandom, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'b1000, 32'h7700_0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'h0, 32'h0, 1'b0, 1'b0);
    idle(24, 1'b1);

    // Reset with words buffered and a word presented.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'hF, 4'b0001, 32'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Timestamp wrap.
    while (m_ts != 16'hFFFF) idle(1, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b0010, 32'h0000_EE00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'b0010, 32'h0000_EF00, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Randomised traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), 4'($urandom | $urandom),
           4'($urandom), $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));

    idle(30, 1'b1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
